instr_sequencer: RTL

Multi-cycle control unit for the 8-bit datapath of the 16-bit-instruction CPU. It fetches each 16-bit instruction as two bytes over the 8-bit memory port, decodes it, and sequences the datapath: register-file ports, ALU op, operand 2:1 mux select and writeback mux select. It owns the PC, the instruction register and the zero flag. It sits between instruction/data memory and the register file/ALU datapath.

---
 rtl/cpu_pkg.sv | 42 ++++
 rtl/instr_decode.sv | 34 +++
 rtl/instr_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit-instruction CPU control path:
// opcode values, ALU operation encodings, sequencer states and the
// decoded instruction-class bundle.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_MOV  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_BZ   = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH_HI = 3'd0,
        ST_FETCH_LO = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_MEM      = 3'd4,
        ST_WB       = 3'd5,
        ST_HALT     = 3'd6
    } state_t;

    // One-hot-ish instruction class flags; NOP has none set.
    typedef struct packed {
        logic wb_op;    // LDI, ADD, SUB, MOV: register writeback from ALU
        logic jmp;
        logic bz;
        logic ld;
        logic st;
        logic halt;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: instruction class flags plus the
// datapath selects (ALU op, operand mux, writeback mux).
module instr_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_t  cls,
    output logic       src_sel,
    output logic [1:0] alu_op,
    output logic       wb_sel
);

    // Map each opcode to its class and datapath controls
    always_comb begin
        cls     = '0;
        src_sel = 1'b0;
        alu_op  = ALU_PASS;
        wb_sel  = 1'b0;
        case (opcode)
            OP_NOP:  cls.illegal = 1'b0;
            OP_LDI:  begin cls.wb_op = 1'b1; src_sel = 1'b1; alu_op = ALU_PASS; end
            OP_ADD:  begin cls.wb_op = 1'b1; alu_op = ALU_ADD; end
            OP_SUB:  begin cls.wb_op = 1'b1; alu_op = ALU_SUB; end
            OP_MOV:  begin cls.wb_op = 1'b1; alu_op = ALU_PASS; end
            OP_JMP:  cls.jmp = 1'b1;
            OP_BZ:   cls.bz = 1'b1;
            OP_LD:   begin cls.ld = 1'b1; wb_sel = 1'b1; end
            OP_ST:   cls.st = 1'b1;
            OP_HALT: cls.halt = 1'b1;
            default: cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control unit: fetches 16-bit instructions as two bytes,
// decodes them and sequences the 8-bit datapath. Owns PC, IR and the
// zero flag. Memory and register-file strobes are registered outputs.
// Build option: ILLEGAL_TRAP_EN -- when defined, an illegal opcode halts
// the sequencer; otherwise it executes as a NOP.
module instr_sequencer
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic [1:0] rf_raddr_a,
    output logic [1:0] rf_raddr_b,
    output logic       rf_we,
    output logic [1:0] rf_waddr,
    output logic       src_sel,
    output logic       wb_sel,
    output logic [1:0] alu_op,
    output logic [7:0] imm,
    input  logic       alu_zero,
    output logic [7:0] pc,
    output logic       halted
);

    state_t      state_r, next_state_s;
    logic [7:0]  pc_r, pc_next_s;
    logic [15:0] ir_r, ir_next_s;
    logic        z_r, z_next_s;
    logic        zpend_r, zpend_next_s;   // flag value waiting for WB
    logic        acc_done_s;

    logic        mem_req_r, mem_req_next_s;
    logic        mem_we_r, mem_we_next_s;
    logic [7:0]  mem_addr_r, mem_addr_next_s;
    logic        rf_we_r, rf_we_next_s;
    logic        halted_r, halted_next_s;
    logic        src_sel_r, wb_sel_r;
    logic [1:0]  alu_op_r;

    op_class_t   cls_s;
    logic        dec_src_sel_s, dec_wb_sel_s;
    logic [1:0]  dec_alu_op_s;

    instr_decode u_decode (
        .opcode  (ir_r[15:12]),
        .cls     (cls_s),
        .src_sel (dec_src_sel_s),
        .alu_op  (dec_alu_op_s),
        .wb_sel  (dec_wb_sel_s)
    );

    // An access completes only when our own request is acknowledged
    assign acc_done_s = mem_req_r & mem_ack;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH_HI;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state sequencing
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_FETCH_HI: if (acc_done_s) next_state_s = ST_FETCH_LO; else next_state_s = ST_FETCH_HI;
            ST_FETCH_LO: if (acc_done_s) next_state_s = ST_DECODE; else next_state_s = ST_FETCH_LO;
            ST_DECODE:   next_state_s = ST_EXEC;
            ST_EXEC: begin
                if (cls_s.wb_op) begin
                    next_state_s = ST_WB;
                end else if (cls_s.ld | cls_s.st) begin
                    next_state_s = ST_MEM;
                end else if (cls_s.halt) begin
                    next_state_s = ST_HALT;
                end else if (cls_s.illegal) begin
`ifdef ILLEGAL_TRAP_EN
                    next_state_s = ST_HALT;
`else
                    next_state_s = ST_FETCH_HI;
`endif
                end else begin
                    next_state_s = ST_FETCH_HI;
                end
            end
            ST_MEM: begin
                if (acc_done_s) begin
                    if (cls_s.ld) next_state_s = ST_WB; else next_state_s = ST_FETCH_HI;
                end else begin
                    next_state_s = ST_MEM;
                end
            end
            ST_WB:   next_state_s = ST_FETCH_HI;
            ST_HALT: next_state_s = ST_HALT;
            default: next_state_s = ST_FETCH_HI;
        endcase
    end

    // Next values of PC, IR and the zero flag
    always_comb begin
        pc_next_s    = pc_r;
        ir_next_s    = ir_r;
        z_next_s     = z_r;
        zpend_next_s = zpend_r;
        case (state_r)
            ST_FETCH_HI: begin
                if (acc_done_s) begin
                    ir_next_s[15:8] = mem_rdata;
                    pc_next_s       = pc_r + 8'd1;
                end else begin
                    pc_next_s = pc_r;
                end
            end
            ST_FETCH_LO: begin
                if (acc_done_s) begin
                    ir_next_s[7:0] = mem_rdata;
                    pc_next_s      = pc_r + 8'd1;
                end else begin
                    pc_next_s = pc_r;
                end
            end
            ST_EXEC: begin
                zpend_next_s = alu_zero;
                if (cls_s.jmp | (cls_s.bz & z_r)) pc_next_s = ir_r[7:0]; else pc_next_s = pc_r;
            end
            ST_MEM: begin
                if (acc_done_s & cls_s.ld) zpend_next_s = (mem_rdata == 8'h00); else zpend_next_s = zpend_r;
            end
            ST_WB:   z_next_s = zpend_r;
            default: z_next_s = z_r;
        endcase
    end

    // Architectural state: PC, instruction register, zero flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r    <= 8'h00;
            ir_r    <= 16'h0000;
            z_r     <= 1'b0;
            zpend_r <= 1'b0;
        end else begin
            pc_r    <= pc_next_s;
            ir_r    <= ir_next_s;
            z_r     <= z_next_s;
            zpend_r <= zpend_next_s;
        end
    end

    // Output decode from the upcoming state so strobes can be registered
    always_comb begin
        mem_req_next_s  = (next_state_s == ST_FETCH_HI) || (next_state_s == ST_FETCH_LO) ||
                          (next_state_s == ST_MEM);
        mem_we_next_s   = (next_state_s == ST_MEM) && cls_s.st;
        if (next_state_s == ST_MEM) mem_addr_next_s = ir_r[7:0]; else mem_addr_next_s = pc_next_s;
        rf_we_next_s    = (next_state_s == ST_WB);
        halted_next_s   = (next_state_s == ST_HALT);
    end

    // Registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_r  <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= 8'h00;
            rf_we_r    <= 1'b0;
            halted_r   <= 1'b0;
            src_sel_r  <= 1'b0;
            wb_sel_r   <= 1'b0;
            alu_op_r   <= ALU_PASS;
        end else begin
            mem_req_r  <= mem_req_next_s;
            mem_we_r   <= mem_we_next_s;
            mem_addr_r <= mem_addr_next_s;
            rf_we_r    <= rf_we_next_s;
            halted_r   <= halted_next_s;
            src_sel_r  <= dec_src_sel_s;
            wb_sel_r   <= dec_wb_sel_s;
            alu_op_r   <= dec_alu_op_s;
        end
    end

    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign rf_we      = rf_we_r;
    assign halted     = halted_r;
    assign src_sel    = src_sel_r;
    assign wb_sel     = wb_sel_r;
    assign alu_op     = alu_op_r;
    assign rf_raddr_a = ir_r[11:10];
    assign rf_raddr_b = ir_r[9:8];
    assign rf_waddr   = ir_r[11:10];
    assign imm        = ir_r[7:0];
    assign pc         = pc_r;

endmodule
